// File: rtl/adc_wbs_packetizer.sv
// Packs the four ADC channels into one sample word, buffers it in a show-ahead FIFO
// and streams fixed-length bursts out of a pipelined Wishbone source.
module adc_wbs_packetizer #(
  parameter int g_adc_data_width = 16,
  parameter int g_packet_size    = 32,
  parameter int g_fifo_depth     = 64
) (
  input  logic                            clk_sys_i,
  input  logic                            sys_rst_n_i,
  input  logic [g_adc_data_width-1:0]     adc_data_ch0_i,
  input  logic [g_adc_data_width-1:0]     adc_data_ch1_i,
  input  logic [g_adc_data_width-1:0]     adc_data_ch2_i,
  input  logic [g_adc_data_width-1:0]     adc_data_ch3_i,
  input  logic                            adc_data_valid_i,
  input  logic                            enable_i,
  input  logic                            ovf_clr_i,
  output logic [1:0]                      wbs_adr_o,
  output logic [4*g_adc_data_width-1:0]   wbs_dat_o,
  output logic                            wbs_cyc_o,
  output logic                            wbs_stb_o,
  output logic                            wbs_we_o,
  output logic [4*g_adc_data_width/8-1:0] wbs_sel_o,
  input  logic                            wbs_ack_i,
  input  logic                            wbs_stall_i,
  input  logic                            wbs_err_i,
  input  logic                            wbs_rty_i,
  output logic                            overflow_o,
  output logic                            bus_err_o,
  output logic [31:0]                     pkt_count_o
);

  localparam int W  = 4 * g_adc_data_width;
  localparam int SW = W / 8;
  localparam int AW = $clog2(g_fifo_depth);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(g_packet_size + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_WAIT_ACK
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  mem [g_fifo_depth];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [LW-1:0] level;
  logic [CW-1:0] sent_cnt, outstanding, outstanding_next;
  logic          capture, fifo_full, push, accept, resp, last_accept, start_burst;

  assign capture     = adc_data_valid_i & enable_i;
  assign fifo_full   = (level == LW'(g_fifo_depth));
  assign push        = capture & ~fifo_full;
  assign accept      = wbs_stb_o & ~wbs_stall_i;
  assign resp        = wbs_cyc_o & (wbs_ack_i | wbs_err_i | wbs_rty_i);
  assign last_accept = accept & (sent_cnt == CW'(g_packet_size - 1));
  assign rd_ptr_inc  = rd_ptr + AW'(1);

  always_comb begin
    outstanding_next = outstanding;
    if (accept && !resp)
      outstanding_next = outstanding + CW'(1);
    else if (!accept && resp)
      outstanding_next = outstanding - CW'(1);
  end

  // Leaving WAIT_ACK looks at the post-response count so cyc drops on the final ack edge.
  always_comb begin
    state_next  = state;
    start_burst = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_i && (level >= LW'(g_packet_size))) begin
          state_next  = ST_BURST;
          start_burst = 1'b1;
        end
      end
      ST_BURST: begin
        if (last_accept)
          state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (outstanding_next == '0)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (push)
      mem[wr_ptr] <= {adc_data_ch3_i, adc_data_ch2_i, adc_data_ch1_i, adc_data_ch0_i};
  end

  always_ff @(posedge clk_sys_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (accept)
        rd_ptr <= rd_ptr_inc;
      level <= level + LW'(push) - LW'(accept);
      if (capture && fifo_full)
        overflow_o <= 1'b1;
      else if (ovf_clr_i)
        overflow_o <= 1'b0;
      if (resp && (wbs_err_i || wbs_rty_i))
        bus_err_o <= 1'b1;
      else if (ovf_clr_i)
        bus_err_o <= 1'b0;
    end
  end

  // The next head word is already in the FIFO for every non-final acceptance of a burst.
  always_ff @(posedge clk_sys_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state       <= ST_IDLE;
      wbs_cyc_o   <= 1'b0;
      wbs_stb_o   <= 1'b0;
      wbs_we_o    <= 1'b0;
      wbs_adr_o   <= '0;
      wbs_sel_o   <= '1;
      wbs_dat_o   <= '0;
      sent_cnt    <= '0;
      outstanding <= '0;
      pkt_count_o <= '0;
    end else begin
      state       <= state_next;
      wbs_cyc_o   <= (state_next != ST_IDLE);
      wbs_stb_o   <= (state_next == ST_BURST);
      wbs_we_o    <= (state_next != ST_IDLE);
      wbs_adr_o   <= '0;
      wbs_sel_o   <= {SW{1'b1}};
      outstanding <= outstanding_next;
      if (start_burst) begin
        wbs_dat_o <= mem[rd_ptr];
        sent_cnt  <= '0;
      end else if (accept) begin
        sent_cnt <= sent_cnt + CW'(1);
        if (!last_accept)
          wbs_dat_o <= mem[rd_ptr_inc];
      end
      if ((state == ST_WAIT_ACK) && (state_next == ST_IDLE))
        pkt_count_o <= pkt_count_o + 32'd1;
    end
  end

endmodule
